game_seq_ctl: RTL and testbench
===============================

GAME_SEQ_CTL -- requirements
Module: game_seq_ctl

Interface
REQ-001 SHALL have parameter FADE_STEP_FRAMES, default 2, frames per fade_level step.
REQ-002 SHALL have parameter FRAMES_PER_SEC, default 60, frames per play-timer second.
REQ-003 SHALL have parameter WIN_LEVEL, default 3, level on which win_zone ends the game.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 vblnk  input  1  vertical blank from VGA timing; each rising edge is one frame.
REQ-007 key_space  input  1  space key level.
REQ-008 key_esc  input  1  escape key level.
REQ-009 level_in  input  2  current level from character controller.
REQ-010 win_zone  input  1  character inside goal region.
REQ-011 game_state  output  3  current sequencer state code.
REQ-012 phys_en  output  1  one-cycle physics enable per frame.
REQ-013 ctl_rst  output  1  reset request to character controller.
REQ-014 fade_level  output  4  screen brightness, 0 = black, 15 = full.
REQ-015 screen_sel  output  2  overlay select: 0 TITLE, 1 GAME, 2 PAUSE, 3 WIN.
REQ-016 play_time_s  output  12  elapsed play seconds, saturating.

Function
REQ-017 States SHALL be TITLE, START, PLAY, PAUSE, FADE_OUT, FADE_IN, WIN.
REQ-018 Key and vblnk events SHALL be rising edges, detected one register stage after the input; a held key SHALL produce one event.
REQ-019 TITLE: screen_sel=0, fade_level=15, phys_en=0; space edge -> START.
REQ-020 START: ctl_rst=1 for exactly 4 clk cycles; play_time_s and frame counter cleared; level_prev loaded from level_in; then -> PLAY.
REQ-021 PLAY: screen_sel=1, fade_level=15; phys_en=1 for one cycle on each vblnk edge, else 0.
REQ-022 PLAY exits by priority: (win_zone and level_in==WIN_LEVEL) -> WIN; else level_in != level_prev -> FADE_OUT, with level_prev<=level_in; else esc edge -> PAUSE.
REQ-023 FADE_OUT: phys_en=0; fade_level decrements by 1 every FADE_STEP_FRAMES vblnk edges; the edge that reaches 0 -> FADE_IN.
REQ-024 FADE_IN: phys_en=0; fade_level increments with the same cadence; the edge that reaches 15 -> PLAY.
REQ-025 Fade step counter SHALL clear on entering FADE_OUT and FADE_IN.
REQ-026 A level_in change during FADE_OUT or FADE_IN SHALL be ignored until PLAY; a pending difference is then detected on the first PLAY cycle.
REQ-027 PAUSE: screen_sel=2, fade_level=8, phys_en=0; esc edge -> PLAY with fade_level 15; space is ignored.
REQ-028 WIN: screen_sel=3, fade_level=15, phys_en=0, play_time_s frozen; space edge -> TITLE.
REQ-029 Play timer SHALL count vblnk edges in PLAY, FADE_OUT and FADE_IN only.
REQ-030 At FRAMES_PER_SEC frames the frame counter SHALL clear and play_time_s increment, saturating at 4095.
REQ-031 A vblnk edge coinciding with a state transition SHALL be credited to the state in which it is sampled (the current state).
REQ-032 game_state codes SHALL be: TITLE 0, START 1, PLAY 2, PAUSE 3, FADE_OUT 4, FADE_IN 5, WIN 6.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst SHALL be synchronous and active-high, with clk as clock.
REQ-035 On reset: state=TITLE, phys_en=0, ctl_rst=1, fade_level=15, screen_sel=0, play_time_s=0.
REQ-036 On reset: level_prev=0; all counters and edge-detector registers =0.
REQ-037 ctl_rst SHALL drop on the first cycle after rst deasserts.
REQ-038 Reset mid-fade or mid-pause SHALL return to TITLE with no residual phys_en pulse.

Structure
REQ-039 game_pkg SHALL hold the game_state_t enum, the screen_sel encoding, FADE_MAX=15 and PAUSE_DIM=8.
REQ-040 A single sub-module rise_edge_det SHALL be instantiated three times, for vblnk, key_space and key_esc.

Verification
REQ-041 Reset, then space pulse: game_state 0->1->2; ctl_rst high exactly 4 cycles; thereafter phys_en exactly 1 cycle per vblnk edge.
REQ-042 In PLAY, level_in 0->1: fade_level 15->0 over 30 frames, then 0->15 over 30 frames; phys_en=0 throughout; then PLAY.
REQ-043 In PLAY, esc: fade_level=8, no phys_en for 100 frames, play_time_s unchanged; second esc -> PLAY.
REQ-044 level_in=3 and win_zone=1 with a simultaneous level change: WIN wins; play_time_s frozen; space -> TITLE.
REQ-045 FRAMES_PER_SEC=1, 4200 frames in PLAY: play_time_s saturates at 4095.
REQ-046 rst asserted during FADE_OUT at fade_level=7: next cycle TITLE, fade_level=15, phys_en=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer: state codes, overlay
// encoding, brightness levels and the saturating play-timer increment.
package game_pkg;

    typedef enum logic [2:0] {
        ST_TITLE    = 3'd0,
        ST_START    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_FADE_OUT = 3'd4,
        ST_FADE_IN  = 3'd5,
        ST_WIN      = 3'd6
    } game_state_t;

    typedef enum logic [1:0] {
        SCR_TITLE = 2'd0,
        SCR_GAME  = 2'd1,
        SCR_PAUSE = 2'd2,
        SCR_WIN   = 2'd3
    } screen_sel_t;

    localparam logic [3:0]  FADE_MAX       = 4'd15;
    localparam logic [3:0]  PAUSE_DIM      = 4'd8;
    localparam int          CTL_RST_CYCLES = 4;
    localparam logic [11:0] PLAY_TIME_MAX  = 12'hFFF;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == PLAY_TIME_MAX) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Registered rising-edge detector: one-cycle pulse the clock after the input
// is first sampled high; a held level yields a single pulse.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
            pulse <= 1'b0;
        end else begin
            din_q <= din;
            pulse <= din & ~din_q;
        end
    end

endmodule

// File: rtl/game_seq_ctl.sv
// Game sequencer: title / play / pause / level-fade / win flow, per-frame
// physics enable and a saturating play-seconds timer.
//
// state    | meaning
// TITLE    | title overlay, waiting for space
// START    | character controller held in reset, timer cleared
// PLAY     | game running, physics enabled once per frame
// PAUSE    | dimmed pause overlay, waiting for esc
// FADE_OUT | level change, brightness stepping down to black
// FADE_IN  | brightness stepping back up to full
// WIN      | win overlay, timer frozen, waiting for space
module game_seq_ctl
    import game_pkg::*;
#(
    parameter int FADE_STEP_FRAMES = 2,
    parameter int FRAMES_PER_SEC   = 60,
    parameter int WIN_LEVEL        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        key_space,
    input  logic        key_esc,
    input  logic [1:0]  level_in,
    input  logic        win_zone,
    output logic [2:0]  game_state,
    output logic        phys_en,
    output logic        ctl_rst,
    output logic [3:0]  fade_level,
    output logic [1:0]  screen_sel,
    output logic [11:0] play_time_s
);

    localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int STEP_W  = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FADE_STEP_FRAMES - 1);
    localparam logic [1:0]         WIN_LVL    = 2'(WIN_LEVEL);
    localparam logic [1:0]         START_LOAD = 2'(CTL_RST_CYCLES - 1);

    game_state_t        state;
    logic [1:0]         level_prev;
    logic [FRAME_W-1:0] frame_cnt;
    logic [STEP_W-1:0]  step_cnt;
    logic [1:0]         start_cnt;
    logic               vblnk_edge;
    logic               space_edge;
    logic               esc_edge;
    logic               timing_state;
    logic               frame_tick;
    logic               step_done;
    logic               sec_done;

    rise_edge_det u_vblnk_det (.clk(clk), .rst(rst), .din(vblnk),     .pulse(vblnk_edge));
    rise_edge_det u_space_det (.clk(clk), .rst(rst), .din(key_space), .pulse(space_edge));
    rise_edge_det u_esc_det   (.clk(clk), .rst(rst), .din(key_esc),   .pulse(esc_edge));

    // The play clock keeps running through level fades but not while paused.
    assign timing_state = (state == ST_PLAY) || (state == ST_FADE_OUT) || (state == ST_FADE_IN);
    assign frame_tick   = vblnk_edge & timing_state;
    assign step_done    = (step_cnt == STEP_LAST);
    assign sec_done     = (frame_cnt == FRAME_LAST);
    assign game_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_TITLE;
            phys_en     <= 1'b0;
            ctl_rst     <= 1'b1;
            fade_level  <= FADE_MAX;
            screen_sel  <= SCR_TITLE;
            play_time_s <= '0;
            level_prev  <= '0;
            frame_cnt   <= '0;
            step_cnt    <= '0;
            start_cnt   <= '0;
        end else begin
            phys_en <= 1'b0;
            ctl_rst <= 1'b0;

            if (frame_tick) begin
                if (sec_done) begin
                    frame_cnt   <= '0;
                    play_time_s <= sat_inc12(play_time_s);
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            case (state)
                ST_TITLE: begin
                    if (space_edge) begin
                        state      <= ST_START;
                        ctl_rst    <= 1'b1;
                        start_cnt  <= START_LOAD;
                        screen_sel <= SCR_GAME;
                        fade_level <= FADE_MAX;
                    end
                end

                ST_START: begin
                    frame_cnt   <= '0;
                    play_time_s <= '0;
                    level_prev  <= level_in;
                    if (start_cnt == 2'd0) begin
                        state <= ST_PLAY;
                    end else begin
                        ctl_rst   <= 1'b1;
                        start_cnt <= start_cnt - 1'b1;
                    end
                end

                ST_PLAY: begin
                    phys_en <= vblnk_edge;
                    if (win_zone && (level_in == WIN_LVL)) begin
                        state      <= ST_WIN;
                        screen_sel <= SCR_WIN;
                        fade_level <= FADE_MAX;
                    end else if (level_in != level_prev) begin
                        state      <= ST_FADE_OUT;
                        level_prev <= level_in;
                        step_cnt   <= '0;
                    end else if (esc_edge) begin
                        state      <= ST_PAUSE;
                        screen_sel <= SCR_PAUSE;
                        fade_level <= PAUSE_DIM;
                    end
                end

                ST_FADE_OUT: begin
                    if (vblnk_edge) begin
                        if (step_done) begin
                            step_cnt   <= '0;
                            fade_level <= fade_level - 4'd1;
                            if (fade_level == 4'd1) begin
                                state <= ST_FADE_IN;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end

                ST_FADE_IN: begin
                    if (vblnk_edge) begin
                        if (step_done) begin
                            step_cnt   <= '0;
                            fade_level <= fade_level + 4'd1;
                            if (fade_level == FADE_MAX - 4'd1) begin
                                state <= ST_PLAY;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (esc_edge) begin
                        state      <= ST_PLAY;
                        screen_sel <= SCR_GAME;
                        fade_level <= FADE_MAX;
                    end
                end

                ST_WIN: begin
                    if (space_edge) begin
                        state      <= ST_TITLE;
                        screen_sel <= SCR_TITLE;
                        fade_level <= FADE_MAX;
                    end
                end

                default: begin
                    state      <= ST_TITLE;
                    screen_sel <= SCR_TITLE;
                    fade_level <= FADE_MAX;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_seq_ctl.sv
// Scoreboard bench for game_seq_ctl: a frame/key-level model queues the expected
// visible state on every change; a monitor pops and compares as the DUT moves.
module tb_game_seq_ctl;

    localparam int FSF  = 2;
    localparam int FPS  = 4;
    localparam int WINL = 3;
    localparam int S_TITLE = 0, S_START = 1, S_PLAY = 2, S_PAUSE = 3;
    localparam int S_FOUT = 4, S_FIN = 5, S_WIN = 6;

    logic        clk = 1'b0;
    logic        rst, vblnk, key_space, key_esc, win_zone;
    logic [1:0]  level_in;
    logic [2:0]  game_state, game_state_s;
    logic        phys_en, phys_en_s, ctl_rst, ctl_rst_s;
    logic [3:0]  fade_level, fade_level_s;
    logic [1:0]  screen_sel, screen_sel_s;
    logic [11:0] play_time_s, play_time_s_s;

    always #5 clk = ~clk;

    game_seq_ctl #(.FADE_STEP_FRAMES(FSF), .FRAMES_PER_SEC(FPS), .WIN_LEVEL(WINL)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .key_space(key_space), .key_esc(key_esc),
        .level_in(level_in), .win_zone(win_zone), .game_state(game_state), .phys_en(phys_en),
        .ctl_rst(ctl_rst), .fade_level(fade_level), .screen_sel(screen_sel), .play_time_s(play_time_s)
    );

    // Same stimulus, one frame per second, so the timer reaches saturation.
    game_seq_ctl #(.FADE_STEP_FRAMES(FSF), .FRAMES_PER_SEC(1), .WIN_LEVEL(WINL)) dut_s (
        .clk(clk), .rst(rst), .vblnk(vblnk), .key_space(key_space), .key_esc(key_esc),
        .level_in(level_in), .win_zone(win_zone), .game_state(game_state_s), .phys_en(phys_en_s),
        .ctl_rst(ctl_rst_s), .fade_level(fade_level_s), .screen_sel(screen_sel_s), .play_time_s(play_time_s_s)
    );

    typedef struct {
        int st; int scr; int fade; int pt; int pts; int phys; int ctl_hi; int ctl;
    } exp_t;

    exp_t exp_q[$];
    int n_pass = 0;
    int n_total = 0;

    int m_state, m_fade, m_frames, m_fframes, m_prev, seg_phys;

    task automatic chk(input string nm, input logic [31:0] act, input int exp_v);
        n_total++;
        if (act === 32'(exp_v)) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    endtask

    function automatic int scr_of(input int st);
        case (st)
            S_TITLE: return 0;
            S_PLAY:  return 1;
            S_PAUSE: return 2;
            S_WIN:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic push(input int ctl_hi, input int ctl);
        exp_t e;
        int secs;
        secs     = m_frames / FPS;
        e.st     = m_state;
        e.scr    = scr_of(m_state);
        e.fade   = (m_state == S_START) ? -1 : m_fade;
        e.pt     = (m_state == S_START) ? -1 : ((secs > 4095) ? 4095 : secs);
        e.pts    = (m_state == S_START) ? -1 : ((m_frames > 4095) ? 4095 : m_frames);
        e.phys   = seg_phys;
        e.ctl_hi = ctl_hi;
        e.ctl    = ctl;
        seg_phys = 0;
        exp_q.push_back(e);
    endtask

    task automatic eval_play();
        if (m_state != S_PLAY) return;
        if (win_zone && (int'(level_in) == WINL)) begin
            m_state = S_WIN;
            push(-1, -1);
        end else if (int'(level_in) != m_prev) begin
            m_prev    = int'(level_in);
            m_state   = S_FOUT;
            m_fframes = 0;
            m_fade    = 15;
            push(-1, -1);
        end
    endtask

    task automatic model_frame();
        if (m_state == S_PLAY || m_state == S_FOUT || m_state == S_FIN) m_frames++;
        case (m_state)
            S_PLAY: seg_phys++;
            S_FOUT: begin
                m_fframes++;
                if (m_fframes % FSF == 0) begin
                    m_fade = 15 - m_fframes / FSF;
                    if (m_fade == 0) begin
                        m_state   = S_FIN;
                        m_fframes = 0;
                    end
                    push(-1, -1);
                end
            end
            S_FIN: begin
                m_fframes++;
                if (m_fframes % FSF == 0) begin
                    m_fade = m_fframes / FSF;
                    if (m_fade == 15) m_state = S_PLAY;
                    push(-1, -1);
                    eval_play();
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        model_frame();
        vblnk = 1'b1;
        tick(3);
        vblnk = 1'b0;
        tick(3);
    endtask

    task automatic press_space();
        if (m_state == S_TITLE) begin
            m_state = S_START;
            push(-1, -1);
            m_frames = 0;
            m_prev   = int'(level_in);
            m_state  = S_PLAY;
            m_fade   = 15;
            push(4, 0);
            eval_play();
        end else if (m_state == S_WIN) begin
            m_state = S_TITLE;
            m_fade  = 15;
            push(-1, -1);
        end
        key_space = 1'b1;
        tick($urandom_range(1, 4));
        key_space = 1'b0;
        tick(4);
    endtask

    task automatic press_esc();
        if (m_state == S_PLAY) begin
            m_state = S_PAUSE;
            m_fade  = 8;
            push(-1, -1);
        end else if (m_state == S_PAUSE) begin
            m_state = S_PLAY;
            m_fade  = 15;
            push(-1, -1);
            eval_play();
        end
        key_esc = 1'b1;
        tick($urandom_range(1, 4));
        key_esc = 1'b0;
        tick(4);
    endtask

    task automatic set_lw(input int lvl, input int w);
        level_in = 2'(lvl);
        win_zone = (w != 0);
        eval_play();
        tick($urandom_range(3, 6));
    endtask

    task automatic do_reset();
        m_state  = S_TITLE;
        m_fade   = 15;
        m_frames = 0;
        m_prev   = 0;
        push(-1, 1);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    logic [8:0] last_key = 9'h1FF;
    int phys_cnt = 0;
    int ctl_hi_cnt = 0;

    always @(negedge clk) begin
        logic [8:0] k;
        exp_t e;
        k = {game_state, screen_sel, fade_level};
        if (k !== last_key) begin
            last_key = k;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_change: got state=%0d scr=%0d fade=%0d expected no change (t=%0t)",
                         game_state, screen_sel, fade_level, $time);
            end else begin
                e = exp_q.pop_front();
                chk("game_state", game_state, e.st);
                chk("game_state_fps1", game_state_s, e.st);
                if (e.scr >= 0)    chk("screen_sel", screen_sel, e.scr);
                if (e.fade >= 0)   chk("fade_level", fade_level, e.fade);
                if (e.pt >= 0)     chk("play_time_s", play_time_s, e.pt);
                if (e.pts >= 0)    chk("play_time_s_fps1", play_time_s_s, e.pts);
                chk("phys_en_pulses", phys_cnt, e.phys);
                if (e.ctl_hi >= 0) chk("ctl_rst_cycles", ctl_hi_cnt, e.ctl_hi);
                if (e.ctl >= 0)    chk("ctl_rst", ctl_rst, e.ctl);
            end
            phys_cnt   = 0;
            ctl_hi_cnt = 0;
        end
        if (phys_en === 1'b1) phys_cnt++;
        if (ctl_rst === 1'b1 && game_state == 3'(S_START)) ctl_hi_cnt++;
    end

    initial begin
        vblnk = 1'b0; key_space = 1'b0; key_esc = 1'b0; level_in = 2'd0; win_zone = 1'b0;
        seg_phys = 0; m_fframes = 0;
        do_reset();

        repeat (3) frame();
        press_esc();
        press_space();
        repeat ($urandom_range(3, 8)) frame();
        press_space();

        set_lw(1, 0);
        repeat (60) frame();
        repeat ($urandom_range(2, 6)) frame();

        set_lw(2, 0);
        repeat (10 + $urandom_range(0, 20)) frame();
        set_lw(3, 0);
        repeat (125) frame();

        press_esc();
        for (int i = 0; i < 100; i++) begin
            frame();
            if ($urandom_range(0, 9) == 0) press_space();
        end
        press_esc();
        repeat ($urandom_range(2, 7)) frame();

        set_lw(2, 0);
        repeat (60 + $urandom_range(1, 4)) frame();
        set_lw(3, 1);
        repeat (8) frame();
        press_esc();
        set_lw(3, 0);
        press_space();
        repeat (3) frame();

        press_space();
        repeat ($urandom_range(2, 6)) frame();
        set_lw(0, 0);
        repeat (16) frame();
        do_reset();

        press_space();
        while (m_frames < 4094) frame();
        press_esc();
        press_esc();
        frame();
        press_esc();
        press_esc();
        repeat (200) frame();
        press_esc();

        tick(10);
        chk("queue_drained", exp_q.size(), 0);
        chk("tail_phys_en_pulses", phys_cnt, seg_phys);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
